// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a single-outstanding instruction-memory read and presents words to decode through a one-entry skid.
// Optional performance counters are enabled by defining FETCH_STAGE_PERF_EN.
module fetch_stage #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [PC_W-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [15:0]     i_imem_rdata,
    input  logic            i_stall,
    input  logic            i_jump,
    input  logic            i_flush,
    input  logic [PC_W-1:0] i_jump_target,
`ifdef FETCH_STAGE_PERF_EN
    output logic [15:0]     o_fetch_cnt,
    output logic [15:0]     o_drop_cnt,
`endif
    output logic [15:0]     o_instr,
    output logic [3:0]      o_opcode,
    output logic [PC_W-1:0] o_pc,
    output logic            o_valid
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP,
        FULL
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] addr_q;
    logic [15:0]     instr_q;
    logic [PC_W-1:0] out_pc_q;
    logic            valid_q;
    logic [15:0]     skid_instr_q;
    logic [PC_W-1:0] skid_pc_q;
    logic            skid_valid_q;

    logic out_free;
    logic load_rdata;
    logic load_skid;
    logic drop_event;

    // A jump always wins the next PC; otherwise the PC advances only when a response is accepted.
    always_comb begin
        pc_d       = pc_q;
        out_free   = !valid_q || !i_stall;
        load_rdata = (state_q == REQ) && i_imem_ack && !i_jump && out_free && !i_flush;
        load_skid  = (state_q == FULL) && skid_valid_q && !i_jump && !i_stall && !i_flush;
        drop_event = i_imem_ack && ((state_q == DROP) || ((state_q == REQ) && i_jump));
        if (i_jump) begin
            pc_d = i_jump_target;
        end else if ((state_q == REQ) && i_imem_ack) begin
            pc_d = pc_q + PC_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            instr_q      <= '0;
            out_pc_q     <= '0;
            valid_q      <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            pc_q <= pc_d;

            if (i_flush) begin
                valid_q <= 1'b0;
            end else if (load_rdata) begin
                instr_q  <= i_imem_rdata;
                out_pc_q <= addr_q;
                valid_q  <= 1'b1;
            end else if (load_skid) begin
                instr_q  <= skid_instr_q;
                out_pc_q <= skid_pc_q;
                valid_q  <= 1'b1;
            end else if (!i_stall) begin
                valid_q <= 1'b0;
            end

            // Every move into REQ issues the address the PC will hold after this edge.
            case (state_q)
                IDLE: begin
                    addr_q  <= pc_d;
                    state_q <= REQ;
                end
                REQ: begin
                    if (i_imem_ack) begin
                        addr_q <= pc_d;
                        if (!i_jump && !out_free) begin
                            skid_instr_q <= i_imem_rdata;
                            skid_pc_q    <= addr_q;
                            skid_valid_q <= 1'b1;
                            state_q      <= FULL;
                        end else begin
                            state_q <= REQ;
                        end
                    end else if (i_jump) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (i_imem_ack) begin
                        addr_q  <= pc_d;
                        state_q <= REQ;
                    end
                end
                FULL: begin
                    if (i_jump || !i_stall) begin
                        skid_valid_q <= 1'b0;
                        addr_q       <= pc_d;
                        state_q      <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (i_jump) begin
                skid_valid_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_STAGE_PERF_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] drop_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if ((load_rdata || load_skid) && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (drop_event && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_drop_cnt  = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop_event;
`endif

    assign o_imem_req  = (state_q == REQ) || (state_q == DROP);
    assign o_imem_addr = addr_q;
    assign o_instr     = instr_q;
    assign o_opcode    = instr_q[15:12];
    assign o_pc        = out_pc_q;
    assign o_valid     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; the bench itself plays instruction memory (rdata = 0x1000 + addr).
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imemReq;
    logic [7:0]  imemAddr;
    logic        imemAck;
    logic [15:0] imemRdata;
    logic        stall;
    logic        jump;
    logic        flush;
    logic [7:0]  jumpTarget;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [7:0]  pc;
    logic        valid;
`ifdef FETCH_STAGE_PERF_EN
    logic [15:0] fetchCnt;
    logic [15:0] dropCnt;
`endif

    int testsRun;
    int testsFailed;

    fetch_stage #(
        .PC_W     (8),
        .RESET_PC (8'h00)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_req    (imemReq),
        .o_imem_addr   (imemAddr),
        .i_imem_ack    (imemAck),
        .i_imem_rdata  (imemRdata),
        .i_stall       (stall),
        .i_jump        (jump),
        .i_flush       (flush),
        .i_jump_target (jumpTarget),
`ifdef FETCH_STAGE_PERF_EN
        .o_fetch_cnt   (fetchCnt),
        .o_drop_cnt    (dropCnt),
`endif
        .o_instr       (instr),
        .o_opcode      (opcode),
        .o_pc          (pc),
        .o_valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // ackMode: 0 = no ack, 1 = ack whenever a request is up, 2 = stray ack with junk data
    task automatic applyStimulus(input logic s, input logic j, input logic f,
                                 input logic [7:0] tgt, input int ackMode);
        stall      = s;
        jump       = j;
        flush      = f;
        jumpTarget = tgt;
        imemAck    = (ackMode == 2) || ((ackMode == 1) && imemReq);
        imemRdata  = (ackMode == 2) ? 16'hDEAD : (16'h1000 + {8'h00, imemAddr});
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        jump        = 1'b0;
        flush       = 1'b0;
        jumpTarget  = 8'h00;
        imemAck     = 1'b0;
        imemRdata   = 16'h0000;

        applyStimulus(0, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("rst_req", {31'd0, imemReq}, 32'd0);
        checkOutput("rst_valid", {31'd0, valid}, 32'd0);
        checkOutput("rst_instr", {16'd0, instr}, 32'd0);
        checkOutput("rst_pc", {24'd0, pc}, 32'd0);
        checkOutput("rst_addr", {24'd0, imemAddr}, 32'd0);
`ifdef FETCH_STAGE_PERF_EN
        checkOutput("rst_fetch_cnt", {16'd0, fetchCnt}, 32'd0);
        checkOutput("rst_drop_cnt", {16'd0, dropCnt}, 32'd0);
`endif

        // Streaming with zero-wait acks
        rst = 1'b0;
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("idle_to_req", {31'd0, imemReq}, 32'd1);
        checkOutput("first_addr", {24'd0, imemAddr}, 32'd0);
        checkOutput("cycle1_valid", {31'd0, valid}, 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("cycle2_valid", {31'd0, valid}, 32'd1);
        checkOutput("cycle2_instr", {16'd0, instr}, 32'h1000);
        checkOutput("cycle2_pc", {24'd0, pc}, 32'd0);
        checkOutput("cycle2_opcode", {28'd0, opcode}, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 1);
            checkOutput("stream_pc", {24'd0, pc}, i);
            checkOutput("stream_instr", {16'd0, instr}, 32'h1000 + i);
            checkOutput("stream_valid", {31'd0, valid}, 32'd1);
        end

        // Three stall cycles with o_pc=4: next word parks in the skid
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 8'h00, 1);
            checkOutput("stall_pc", {24'd0, pc}, 32'd4);
            checkOutput("stall_instr", {16'd0, instr}, 32'h1004);
            checkOutput("stall_valid", {31'd0, valid}, 32'd1);
            checkOutput("stall_req_low", {31'd0, imemReq}, 32'd0);
        end
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("skid_pc", {24'd0, pc}, 32'd5);
        checkOutput("skid_instr", {16'd0, instr}, 32'h1005);
        checkOutput("skid_valid", {31'd0, valid}, 32'd1);
        checkOutput("skid_next_addr", {24'd0, imemAddr}, 32'd6);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("after_skid_pc", {24'd0, pc}, 32'd6);
        checkOutput("after_skid_instr", {16'd0, instr}, 32'h1006);

        // Jump to 0x40 while the request for 7 waits two cycles for its ack
        applyStimulus(0, 1, 0, 8'h40, 0);
        checkOutput("drop_req", {31'd0, imemReq}, 32'd1);
        checkOutput("drop_addr_held", {24'd0, imemAddr}, 32'd7);
        checkOutput("drop_valid", {31'd0, valid}, 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("drop_addr_held2", {24'd0, imemAddr}, 32'd7);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("stale_not_valid", {31'd0, valid}, 32'd0);
        checkOutput("redirect_addr", {24'd0, imemAddr}, 32'h40);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("target_pc", {24'd0, pc}, 32'h40);
        checkOutput("target_instr", {16'd0, instr}, 32'h1040);
        checkOutput("target_valid", {31'd0, valid}, 32'd1);

        // Jump plus flush with the ack in the same cycle
        applyStimulus(0, 1, 1, 8'h80, 1);
        checkOutput("flush_valid", {31'd0, valid}, 32'd0);
        checkOutput("flush_addr", {24'd0, imemAddr}, 32'h80);
        checkOutput("flush_req", {31'd0, imemReq}, 32'd1);
`ifdef FETCH_STAGE_PERF_EN
        checkOutput("drop_cnt", {16'd0, dropCnt}, 32'd2);
        checkOutput("fetch_cnt", {16'd0, fetchCnt}, 32'd8);
`endif
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("flush_target_pc", {24'd0, pc}, 32'h80);
        checkOutput("flush_target_instr", {16'd0, instr}, 32'h1080);

        // PC wrap from 0xFF
        applyStimulus(0, 1, 0, 8'hFF, 1);
        checkOutput("wrap_jump_addr", {24'd0, imemAddr}, 32'hFF);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("wrap_pc_ff", {24'd0, pc}, 32'hFF);
        checkOutput("wrap_next_addr", {24'd0, imemAddr}, 32'h00);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("wrap_pc_00", {24'd0, pc}, 32'h00);
        checkOutput("wrap_instr", {16'd0, instr}, 32'h1000);

        // Reset during a pending request, then a stray ack in IDLE
        applyStimulus(1, 0, 0, 8'h00, 0);
        checkOutput("pending_valid", {31'd0, valid}, 32'd1);
        checkOutput("pending_req", {31'd0, imemReq}, 32'd1);
        rst = 1'b1;
        applyStimulus(1, 1, 1, 8'h55, 0);
        checkOutput("midrst_req", {31'd0, imemReq}, 32'd0);
        checkOutput("midrst_valid", {31'd0, valid}, 32'd0);
        checkOutput("midrst_addr", {24'd0, imemAddr}, 32'd0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 8'h00, 2);
        checkOutput("late_ack_valid", {31'd0, valid}, 32'd0);
        checkOutput("restart_addr", {24'd0, imemAddr}, 32'd0);
        checkOutput("restart_req", {31'd0, imemReq}, 32'd1);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("restart_pc", {24'd0, pc}, 32'd0);
        checkOutput("restart_instr", {16'd0, instr}, 32'h1000);
        checkOutput("restart_valid", {31'd0, valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter and instruction-memory address width.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded by reset.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port o_imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port o_imem_addr  output  PC_W  request address, registered.
REQ-007 SHALL have port i_imem_ack  input  1  read complete; i_imem_rdata valid this cycle.
REQ-008 SHALL have port i_imem_rdata  input  16  instruction word.
REQ-009 SHALL have port i_stall  input  1  decode cannot accept; hold o_instr.
REQ-010 SHALL have port i_jump  input  1  redirect PC to i_jump_target.
REQ-011 SHALL have port i_flush  input  1  invalidate o_instr.
REQ-012 SHALL have port i_jump_target  input  PC_W  redirect address.
REQ-013 SHALL have ports o_instr (output, 16), o_opcode (output, 4, = o_instr[15:12]), o_pc (output, PC_W, address of o_instr) and o_valid (output, 1, o_instr holds a live instruction).

Function
REQ-014 SHALL implement states IDLE, REQ, DROP and FULL.
REQ-015 IDLE: o_imem_req=0; next state REQ, with o_imem_addr<=pc.
REQ-016 REQ/DROP: o_imem_req=1 and o_imem_addr stable until i_imem_ack; ack is legal in the first cycle of req.
REQ-017 REQ, ack, no i_jump, output free (!o_valid || !i_stall): o_instr<=rdata, o_pc<=addr, o_valid<=1, pc<=pc+1, o_imem_addr<=pc+1, stay REQ; one-cycle latency, ack edge to o_valid.
REQ-018 REQ, ack, output blocked: rdata and addr go to a one-entry skid register; pc<=pc+1; go to FULL.
REQ-019 FULL: o_imem_req=0; when !i_stall, skid moves to o_instr/o_pc with o_valid=1; go to REQ.
REQ-020 o_valid with i_stall=1 and no i_flush: o_instr, o_pc and o_valid SHALL hold.
REQ-021 o_valid with i_stall=0 and no new data: o_valid<=0 next edge.
REQ-022 i_jump: pc<=i_jump_target; clear skid.
REQ-023 i_jump in REQ without ack: go to DROP.
REQ-024 i_jump in REQ with ack in the same cycle: discard rdata; next state REQ with o_imem_addr<=i_jump_target.
REQ-025 DROP: on ack, discard rdata; go to REQ with o_imem_addr<=pc.
REQ-026 i_flush: o_valid<=0 next edge, overriding i_stall and any load that cycle; PC unaffected unless i_jump also set.
REQ-027 i_jump without i_flush SHALL leave o_instr/o_valid as the stall rules dictate (delay slot).
REQ-028 PC arithmetic SHALL be modulo 2^PC_W; 2^PC_W-1 wraps to 0.
REQ-029 No rdata SHALL be used outside REQ with ack.
REQ-030 At most one request SHALL be outstanding at a time.

Reset
REQ-031 i_rst: state IDLE, pc=RESET_PC, o_imem_addr=RESET_PC, o_imem_req=0, o_valid=0, o_instr=0, o_pc=0, skid empty.
REQ-032 Reset mid-request SHALL drop o_imem_req the next cycle; a late ack while in IDLE SHALL be ignored.
REQ-033 Reset SHALL override i_jump, i_flush and i_stall.

Configuration
REQ-034 With FETCH_STAGE_PERF_EN defined: 16-bit saturating outputs o_fetch_cnt (instructions loaded into o_instr) and o_drop_cnt (responses discarded in DROP or by REQ-024), both zeroed by reset.
REQ-035 Without FETCH_STAGE_PERF_EN: those ports and counters SHALL NOT exist; other behaviour is identical.

Verification
REQ-036 Bench SHALL cover reset, then zero-wait ack every cycle, rdata 0x1000+addr -> o_valid on cycle 2, o_pc 0,1,2,... and o_instr 0x1000,0x1001,... one per cycle.
REQ-037 Bench SHALL cover i_stall=1 for 3 cycles with o_pc=4 -> o_instr held, one word in skid (FULL), req low; release -> o_pc 5 then 6 with no gap or loss.
REQ-038 Bench SHALL cover i_jump with target 0x40 while ack is pending 2 cycles -> DROP, stale word not delivered, next o_pc=0x40.
REQ-039 Bench SHALL cover i_jump plus i_flush with ack in the same cycle -> o_valid=0 next edge, next request addr=target, o_drop_cnt +1 (PERF_EN).
REQ-040 Bench SHALL cover PC 0xFF with PC_W=8 -> next fetch addr 0x00.
REQ-041 Bench SHALL cover i_rst asserted during a pending request -> req=0 and o_valid=0 next cycle; a later ack is ignored; fetch restarts at RESET_PC.
